// File: rtl/sccb_seq_writer.sv
// rtl/sccb_seq_writer.sv - SCCB/I2C register-table write sequencer with ACK checking and retry
// Optional SCCB_DELAY_EN: entries with an all-ones register field become timed waits.
module sccb_seq_writer #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         REG_BYTES   = 2,
  parameter int         DATA_BYTES  = 1,
  parameter int         NUM_ENTRIES = 11,
  parameter int         CLK_DIV     = 62,
  parameter int         MAX_RETRY   = 3,
  parameter int         DELAY_UNIT  = 25000
) (
  input  logic                                ack_clk,
  input  logic                                reset,
  input  logic                                start,
  output logic [7:0]                          tbl_idx,
  input  logic [8*(REG_BYTES+DATA_BYTES)-1:0] tbl_data,
  output logic                                scl,
  output logic                                sda_oe,
  input  logic                                sda_i,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [7:0]                          err_idx
);
  localparam int ENTRY_W = 8 * (REG_BYTES + DATA_BYTES);
  localparam int NBYTES  = 1 + REG_BYTES + DATA_BYTES;
  localparam int SHIFT_W = 8 * NBYTES;
  localparam int REG_W   = 8 * REG_BYTES;
  localparam int DATA_W  = 8 * DATA_BYTES;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int UNIT_W  = $clog2(DELAY_UNIT + 1);

`ifdef SCCB_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DELAY, S_FINISH
  } state_t;

  state_t               state, state_nx;
  logic [DIV_W-1:0]     div_cnt;
  logic [1:0]           qtr;
  logic [2:0]           bit_cnt;
  logic [3:0]           byte_cnt;
  logic [SHIFT_W-1:0]   shift_q;
  logic                 nack;
  logic [7:0]           retry_cnt;
  logic [DATA_W-1:0]    dly_rem;
  logic [UNIT_W-1:0]    dly_unit;

  logic tick, q_end, bus_phase, is_last, retry_ok, dly_entry, dly_end;

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign q_end     = tick && (qtr == 2'd3);
  assign bus_phase = (state == S_START) || (state == S_BYTE) || (state == S_ACK) ||
                     (state == S_STOP)  || (state == S_GAP);
  assign is_last   = (tbl_idx == 8'(NUM_ENTRIES - 1));
  assign retry_ok  = (retry_cnt < 8'(MAX_RETRY));
  assign dly_entry = DELAY_EN && (tbl_data[ENTRY_W-1 -: REG_W] == {REG_W{1'b1}});
  assign dly_end   = (dly_rem == '0) ||
                     ((dly_rem == DATA_W'(1)) && (dly_unit == UNIT_W'(DELAY_UNIT - 1)));

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = dly_entry ? S_DELAY : S_START;
      S_START:  if (q_end) state_nx = S_BYTE;
      S_BYTE:   if (q_end && (bit_cnt == 3'd7)) state_nx = S_ACK;
      S_ACK:    if (q_end) state_nx = (nack || (byte_cnt == 4'(NBYTES - 1))) ? S_STOP : S_BYTE;
      S_STOP:   if (q_end) state_nx = S_GAP;
      S_GAP: begin
        if (q_end) begin
          if (!nack)         state_nx = is_last ? S_FINISH : S_LOAD;
          else if (retry_ok) state_nx = S_LOAD;
          else               state_nx = S_FINISH;
        end
      end
      S_DELAY:  if (dly_end) state_nx = is_last ? S_FINISH : S_LOAD;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Bus levels decode from state and quarter phase; SCL is high in Q1/Q2 of every data/ACK bit.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        scl    = (qtr < 2'd2);
        sda_oe = (qtr != 2'd0);
      end
      S_BYTE: begin
        scl    = qtr[0] ^ qtr[1];
        sda_oe = ~shift_q[SHIFT_W-1];
      end
      S_ACK:   scl = qtr[0] ^ qtr[1];
      S_STOP: begin
        scl    = (qtr != 2'd0);
        sda_oe = (qtr < 2'd2);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_FINISH);
  assign done = (state == S_FINISH);

  always_ff @(posedge ack_clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      nack      <= 1'b0;
      retry_cnt <= '0;
      tbl_idx   <= '0;
      error     <= 1'b0;
      err_idx   <= '0;
      dly_rem   <= '0;
      dly_unit  <= '0;
    end else begin
      if (bus_phase) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) qtr <= qtr + 2'd1;
      end else begin
        div_cnt <= '0;
        qtr     <= '0;
      end

      case (state)
        S_IDLE: if (start) begin
          tbl_idx   <= '0;
          retry_cnt <= '0;
          error     <= 1'b0;
          err_idx   <= '0;
        end
        S_LOAD: begin
          shift_q  <= {DEV_ADDR, 1'b0, tbl_data};
          bit_cnt  <= '0;
          byte_cnt <= '0;
          nack     <= 1'b0;
          dly_rem  <= tbl_data[DATA_W-1:0];
          dly_unit <= '0;
        end
        S_BYTE: if (q_end) begin
          shift_q <= {shift_q[SHIFT_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_ACK: begin
          if (tick && (qtr == 2'd2)) nack <= sda_i;
          if (q_end) byte_cnt <= byte_cnt + 4'd1;
        end
        S_GAP: if (q_end) begin
          if (!nack) begin
            tbl_idx   <= tbl_idx + 8'd1;
            retry_cnt <= '0;
          end else if (retry_ok) begin
            retry_cnt <= retry_cnt + 8'd1;
          end else begin
            error   <= 1'b1;
            err_idx <= tbl_idx;
          end
        end
        S_DELAY: begin
          if (dly_end) begin
            tbl_idx   <= tbl_idx + 8'd1;
            retry_cnt <= '0;
          end else if (dly_unit == UNIT_W'(DELAY_UNIT - 1)) begin
            dly_unit <= '0;
            dly_rem  <= dly_rem - 1'b1;
          end else begin
            dly_unit <= dly_unit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
